// File: rtl/sprite_pkg.sv
// sprite_pkg: shared state type and per-slot cycle costs for the sprite line server
package sprite_pkg;
    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, DATA, NEXT, FIN} sls_state_t;
    localparam int SLS_CYC_EN = 4;
    localparam int SLS_CYC_DIS = 2;
endpackage

// File: rtl/glyph_addr_gen.sv
// glyph_addr_gen: selects one slot's glyph/pos and forms glyph*HEIGHT+pos plus the line range check
module glyph_addr_gen #(
    parameter int NSPR = 8,
    parameter int GLYPHW = 7,
    parameter int POSW = 9,
    parameter int HEIGHT = 8,
    parameter int ADDRW = 10,
    parameter int SW = (NSPR > 1) ? $clog2(NSPR) : 1
) (
    input  logic [SW-1:0]          slot,
    input  logic [NSPR*GLYPHW-1:0] glyph,
    input  logic [NSPR*POSW-1:0]   pos,
    output logic [ADDRW-1:0]       addr,
    output logic                   in_range
);
    import sprite_pkg::*;
    localparam int PRODW = GLYPHW + $clog2(HEIGHT) + 1;
    logic [GLYPHW-1:0] g;
    logic [POSW-1:0]   p;
    logic [PRODW-1:0]  prod;
    logic [ADDRW:0]    sum;
    // mux the active slot, then product and offset; overflow wraps silently into ADDRW bits
    always_comb begin
        g = glyph[int'(slot)*GLYPHW +: GLYPHW];
        p = pos[int'(slot)*POSW +: POSW];
        prod = PRODW'(g) * PRODW'(HEIGHT);
        sum = (ADDRW+1)'(prod) + (ADDRW+1)'(p);
        addr = sum[ADDRW-1:0];
        in_range = 32'(p) < HEIGHT;
    end
endmodule

// File: rtl/sprite_line_server.sv
// sprite_line_server: per-scanline sweep granting each enabled sprite one font ROM line fetch
module sprite_line_server
    import sprite_pkg::*;
#(
    parameter int NSPR = 8,
    parameter int WIDTH = 8,
    parameter int HEIGHT = 8,
    parameter int GLYPHW = 7,
    parameter int POSW = 9,
    parameter int ADDRW = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   line_start,
    input  logic [NSPR-1:0]        slot_en,
    input  logic [NSPR*GLYPHW-1:0] glyph,
    input  logic [NSPR*POSW-1:0]   pos,
    output logic [NSPR-1:0]        dma_avail,
    output logic [ADDRW-1:0]       rom_addr,
    input  logic [WIDTH-1:0]       rom_data,
    output logic [WIDTH-1:0]       data_out,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun
);
    localparam int SW = (NSPR > 1) ? $clog2(NSPR) : 1;
    sls_state_t      state;
    logic [SW-1:0]   slot;
    logic [NSPR-1:0] en_q;
    logic            valid_q;
    logic [ADDRW-1:0] addr;
    logic            in_range;
    glyph_addr_gen #(
        .NSPR(NSPR), .GLYPHW(GLYPHW), .POSW(POSW), .HEIGHT(HEIGHT), .ADDRW(ADDRW), .SW(SW)
    ) u_addr (
        .slot(slot), .glyph(glyph), .pos(pos), .addr(addr), .in_range(in_range)
    );
    // sweep FSM: walk slots in order; glyph/pos are sampled in ISSUE so late pos updates are served
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            slot <= '0;
            en_q <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (line_start) begin
                    en_q <= slot_en;
                    slot <= '0;
                    state <= CHECK;
                end
                CHECK: state <= en_q[slot] ? ISSUE : NEXT;
                ISSUE: begin
                    valid_q <= in_range;
                    state <= DATA;
                end
                DATA: state <= NEXT;
                NEXT: begin
                    if (slot == SW'(NSPR-1)) state <= FIN;
                    else begin
                        slot <= slot + 1'b1;
                        state <= CHECK;
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    // outputs decode from state so a reset leaves no partial grant or stale data on the bus
    always_comb begin
        dma_avail = (state == ISSUE) ? NSPR'(1) << slot : '0;
        rom_addr = (state == ISSUE) ? addr : '0;
        data_out = (state == DATA && valid_q) ? rom_data : '0;
        busy = state != IDLE;
        done = state == FIN;
        overrun = line_start && state != IDLE;
    end
endmodule
